ws2812_tx: RTL and testbench

- Serial output stage for the LED panel. It consumes blended 24-bit pixels from the compositing pipeline over a valid/ready handshake and drives the WS2812 single-wire data pin.
- Contains a one-entry holding register so consecutive pixels stream with no inter-pixel gap.
- Inserts the latch (reset) low period after each frame's last pixel.
- Sits directly downstream of the alpha-blend output; its `dout` goes to the panel data pin.

---
 rtl/ws2812_tx_if.sv | 13 +
 rtl/ws2812_tx.sv | 159 +++++++++++++++
 tb/tb_ws2812_tx.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ws2812_tx_if.sv
// Pixel handshake from the compositing pipeline into the WS2812 serial stage.
// master = pipeline side (drives pixel), slave = ws2812_tx (drives ready).
interface ws2812_tx_if;
  logic       valid;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  logic       last;
  logic       ready;

  modport master (output valid, red, green, blue, last, input ready);
  modport slave  (input valid, red, green, blue, last, output ready);
endinterface

// File: rtl/ws2812_tx.sv
// WS2812 single-wire transmitter: one-entry pixel holding register, GRB MSB-first
// bit shifter with per-bit high-time encoding, and a latch low period after each frame.
module ws2812_tx #(
  parameter int BIT_CYC   = 20,
  parameter int T0H_CYC   = 6,
  parameter int T1H_CYC   = 11,
  parameter int LATCH_CYC = 1280
) (
  input  logic          clk,
  input  logic          rst,
  ws2812_tx_if.slave    px,
  output logic          dout,
  output logic          busy,
  output logic          frame_done,
  output logic          underrun
);

  localparam int CYC_W = $clog2(BIT_CYC + 1);
  localparam int LAT_W = $clog2(LATCH_CYC + 1);

  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYC - 1);
  localparam logic [CYC_W-1:0] T0_C     = CYC_W'(T0H_CYC);
  localparam logic [CYC_W-1:0] T1_C     = CYC_W'(T1H_CYC);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATCH_CYC - 1);
  localparam logic [4:0]       BIT_LAST = 5'd23;

  typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;

  typedef struct packed {
    logic [23:0] grb;
    logic        last;
  } pix_t;

  state_t           state, state_n;
  logic [CYC_W-1:0] cyc_cnt, cyc_n;
  logic [4:0]       bit_cnt, bit_n;
  logic [LAT_W-1:0] lat_cnt, lat_n;
  logic [23:0]      sh, sh_n;
  logic             cur_last, last_n;
  logic             dout_n, fd_n, ur_n;
  logic             load, accept;
  logic             bit_end;
  logic [CYC_W-1:0] hi_cyc;

  pix_t             hold;
  logic             hold_full;
  logic             rdy_en;

  // rdy_en keeps ready low through reset and rises on the first edge after release
  assign px.ready = rdy_en & ~hold_full;
  assign accept   = px.valid & px.ready;
  assign busy     = (state != IDLE);
  assign bit_end  = (cyc_cnt == CYC_LAST);
  assign hi_cyc   = sh[23] ? T1_C : T0_C;

  always_comb begin
    state_n = state;
    cyc_n   = cyc_cnt;
    bit_n   = bit_cnt;
    lat_n   = lat_cnt;
    sh_n    = sh;
    last_n  = cur_last;
    load    = 1'b0;
    dout_n  = 1'b0;
    fd_n    = 1'b0;
    ur_n    = 1'b0;

    case (state)
      IDLE: begin
        if (hold_full) begin
          load    = 1'b1;
          state_n = SEND;
        end
      end

      SEND: begin
        dout_n = (cyc_cnt < hi_cyc);
        cyc_n  = cyc_cnt + CYC_W'(1);
        if (bit_end) begin
          cyc_n = '0;
          sh_n  = {sh[22:0], 1'b0};
          bit_n = bit_cnt + 5'd1;
          if (bit_cnt == BIT_LAST) begin
            bit_n = '0;
            if (cur_last) begin
              state_n = LATCH;
              lat_n   = '0;
            end else if (hold_full) begin
              // chain straight into the next pixel, no idle clock between
              load = 1'b1;
            end else begin
              ur_n    = 1'b1;
              state_n = IDLE;
            end
          end
        end
      end

      LATCH: begin
        lat_n = lat_cnt + LAT_W'(1);
        if (lat_cnt == LAT_LAST) begin
          fd_n    = 1'b1;
          state_n = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase

    if (load) begin
      sh_n   = hold.grb;
      last_n = hold.last;
      cyc_n  = '0;
      bit_n  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cyc_cnt    <= '0;
      bit_cnt    <= '0;
      lat_cnt    <= '0;
      sh         <= '0;
      cur_last   <= 1'b0;
      dout       <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_n;
      cyc_cnt    <= cyc_n;
      bit_cnt    <= bit_n;
      lat_cnt    <= lat_n;
      sh         <= sh_n;
      cur_last   <= last_n;
      dout       <= dout_n;
      frame_done <= fd_n;
      underrun   <= ur_n;
    end
  end

  // Accept and load never coincide (accept needs empty, load needs full)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold      <= '0;
      hold_full <= 1'b0;
      rdy_en    <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (accept) begin
        hold      <= '{grb: {px.green, px.red, px.blue}, last: px.last};
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ws2812_tx.sv
// Directed-sequence bench for ws2812_tx: random pixels, dout decoded from high-run lengths
// and rise spacing, compared against bit timings derived from the GRB words.
module tb_ws2812_tx;
  localparam int BIT_CYC = 20;
  localparam int T0H     = 6;
  localparam int T1H     = 11;
  localparam int LATCH   = 1280;
  localparam int PX_CYC  = 24 * BIT_CYC;
  localparam int TMO     = 5000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dout, busy, frame_done, underrun;

  ws2812_tx_if bus();

  ws2812_tx #(.BIT_CYC(BIT_CYC), .T0H_CYC(T0H), .T1H_CYC(T1H), .LATCH_CYC(LATCH)) dut (
    .clk        (clk),
    .rst        (rst),
    .px         (bus.slave),
    .dout       (dout),
    .busy       (busy),
    .frame_done (frame_done),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  // Line monitor: one sample per clock on the falling edge
  int   cyc = 0;
  int   hi_run = 0;
  logic prev = 1'b0;
  int   rise_t[$];
  int   hi_len[$];
  int   fd_t[$];
  int   ur_t[$];

  always @(negedge clk) begin
    cyc++;
    if (dout === 1'b1) begin
      if (!prev) rise_t.push_back(cyc);
      hi_run++;
    end else begin
      if (prev) hi_len.push_back(hi_run);
      hi_run = 0;
    end
    prev = (dout === 1'b1);
    if (frame_done === 1'b1) fd_t.push_back(cyc);
    if (underrun === 1'b1) ur_t.push_back(cyc);
  end

  int          checks = 0;
  int          errors = 0;
  logic [23:0] exp_px[$];
  logic [23:0] rgb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // acc = monitor index of the clock following the accepting edge
  task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                      input logic l, output int acc);
    int n = 0;
    bus.valid = 1'b1;
    bus.red   = r;
    bus.green = g;
    bus.blue  = b;
    bus.last  = l;
    while (bus.ready !== 1'b1 && n < TMO) begin
      tick();
      n++;
    end
    chk("ready_before_accept", bus.ready, 1'b1);
    tick();
    acc = cyc + 1;
    exp_px.push_back({g, r, b});
    chk("ready_drop", bus.ready, 1'b0);
  endtask

  task automatic wait_fd(input int base, output int t);
    int n = 0;
    while (fd_t.size() <= base && n < TMO) begin
      tick();
      n++;
    end
    chk("fd_wait", fd_t.size() > base, 1);
    t = (fd_t.size() > base) ? fd_t[base] : -1;
  endtask

  // Expected line behaviour derived from the words alone: 24 bits MSB first,
  // high time T1H/T0H per bit, rises BIT_CYC apart within each pixel.
  task automatic check_stream(input string tag, input int rb, input int hb, input bit contig);
    int          nb;
    logic [23:0] w;
    nb = exp_px.size() * 24;
    chk({tag, "_nrise"}, rise_t.size() - rb, nb);
    chk({tag, "_nhigh"}, hi_len.size() - hb, nb);
    if (rise_t.size() - rb == nb && hi_len.size() - hb == nb) begin
      for (int k = 0; k < nb; k++) begin
        w = exp_px[k / 24];
        chk({tag, "_high"}, hi_len[hb + k], w[23 - (k % 24)] ? T1H : T0H);
        if (k > 0 && (contig || (k % 24) != 0))
          chk({tag, "_period"}, rise_t[rb + k] - rise_t[rb + k - 1], BIT_CYC);
      end
    end
  endtask

  task automatic run_stream(input string tag);
    int          acc, acc0, tf, rb, hb, fb, ub, n;
    logic [23:0] p;
    n = rgb_q.size();
    exp_px.delete();
    rb = rise_t.size(); hb = hi_len.size(); fb = fd_t.size(); ub = ur_t.size();
    acc0 = 0;
    for (int i = 0; i < n; i++) begin
      p = rgb_q[i];
      send(p[23:16], p[15:8], p[7:0], i == n - 1, acc);
      if (i == 0) acc0 = acc;
    end
    bus.valid = 1'b0;
    wait_fd(fb, tf);
    check_stream(tag, rb, hb, 1'b1);
    chk({tag, "_fd_time"}, tf - acc0, 1 + n * PX_CYC + LATCH);
    chk({tag, "_no_underrun"}, ur_t.size() - ub, 0);
  endtask

  initial begin
    int          acc, acc0, accb, tf, tf2, rb, hb, fb, ub, n;
    logic [23:0] p;

    bus.valid = 1'b0; bus.red = '0; bus.green = '0; bus.blue = '0; bus.last = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_ready", bus.ready, 1'b0);
    chk("rst_dout", dout, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_fd", frame_done, 1'b0);
    chk("rst_ur", underrun, 1'b0);
    #2 rst = 1'b0;
    #1 chk("ready_before_first_edge", bus.ready, 1'b0);
    tick();
    chk("ready_after_release", bus.ready, 1'b1);

    // Single green pixel, end of frame
    exp_px.delete();
    rb = rise_t.size(); hb = hi_len.size(); fb = fd_t.size(); ub = ur_t.size();
    send(8'h00, 8'hFF, 8'h00, 1'b1, acc);
    bus.valid = 1'b0;
    repeat (10) tick();
    chk("s1_busy_shift", busy, 1'b1);
    wait_fd(fb, tf);
    chk("s1_first_rise", (rise_t.size() > rb) ? rise_t[rb] - acc : -1, 2);
    check_stream("s1", rb, hb, 1'b1);
    chk("s1_fd_time", tf - acc, 1 + PX_CYC + LATCH);
    chk("s1_busy_after", busy, 1'b0);
    repeat (5) tick();
    chk("s1_fd_single", fd_t.size() - fb, 1);
    chk("s1_no_underrun", ur_t.size() - ub, 0);

    // Back-to-back stream, then a random-length random stream
    rgb_q = '{24'h123456, 24'hABCDEF, 24'h000001, 24'h800000};
    run_stream("s2");
    rgb_q.delete();
    n = $urandom_range(2, 5);
    for (int i = 0; i < n; i++) rgb_q.push_back(24'($urandom));
    run_stream("s2r");

    // Starved stream: second pixel arrives 600 clocks after the first
    exp_px.delete();
    rb = rise_t.size(); hb = hi_len.size(); fb = fd_t.size(); ub = ur_t.size();
    p = 24'($urandom);
    send(p[23:16], p[15:8], p[7:0], 1'b0, acc0);
    bus.valid = 1'b0;
    repeat (600) tick();
    chk("s3_ur_count", ur_t.size() - ub, 1);
    chk("s3_ur_time", (ur_t.size() > ub) ? ur_t[ub] - acc0 : -1, 1 + PX_CYC);
    chk("s3_quiet_gap", rise_t.size() - rb, 24);
    chk("s3_dout_low", dout, 1'b0);
    p = 24'($urandom);
    send(p[23:16], p[15:8], p[7:0], 1'b1, accb);
    bus.valid = 1'b0;
    wait_fd(fb, tf);
    check_stream("s3", rb, hb, 1'b0);
    chk("s3_second_rise", (rise_t.size() > rb + 24) ? rise_t[rb + 24] - accb : -1, 2);
    chk("s3_fd_time", tf - accb, 1 + PX_CYC + LATCH);
    chk("s3_ur_total", ur_t.size() - ub, 1);

    // Next frame's first pixel offered during the latch period
    exp_px.delete();
    rb = rise_t.size(); hb = hi_len.size(); fb = fd_t.size(); ub = ur_t.size();
    p = 24'($urandom);
    send(p[23:16], p[15:8], p[7:0], 1'b1, acc0);
    bus.valid = 1'b0;
    repeat (PX_CYC + 100) tick();
    chk("s4_busy_latch", busy, 1'b1);
    chk("s4_dout_latch", dout, 1'b0);
    p = 24'($urandom);
    send(p[23:16], p[15:8], p[7:0], 1'b1, accb);
    bus.valid = 1'b0;
    chk("s4_fd_not_yet", fd_t.size() - fb, 0);
    wait_fd(fb, tf);
    chk("s4_held_quiet", rise_t.size() - rb, 24);
    chk("s4_fd_a_time", tf - acc0, 1 + PX_CYC + LATCH);
    wait_fd(fb + 1, tf2);
    check_stream("s4", rb, hb, 1'b0);
    chk("s4_b_rise", (rise_t.size() > rb + 24) ? rise_t[rb + 24] - tf : -1, 2);
    chk("s4_fd_b_time", tf2 - tf, 1 + PX_CYC + LATCH);
    chk("s4_no_underrun", ur_t.size() - ub, 0);

    // Reset in the middle of bit 10
    exp_px.delete();
    rb = rise_t.size(); fb = fd_t.size(); ub = ur_t.size();
    p = 24'($urandom);
    send(p[23:16], p[15:8], p[7:0], 1'b1, acc0);
    bus.valid = 1'b0;
    n = 0;
    while (rise_t.size() < rb + 11 && n < TMO) begin
      tick();
      n++;
    end
    chk("s5_dout_before_rst", dout, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("s5_dout_async", dout, 1'b0);
    chk("s5_ready_rst", bus.ready, 1'b0);
    chk("s5_busy_rst", busy, 1'b0);
    repeat (3) tick();
    chk("s5_ready_held", bus.ready, 1'b0);
    #2 rst = 1'b0;
    tick();
    chk("s5_ready_release", bus.ready, 1'b1);
    repeat (2000) tick();
    chk("s5_no_fd", fd_t.size() - fb, 0);
    chk("s5_no_ur", ur_t.size() - ub, 0);
    chk("s5_no_more_bits", rise_t.size() - rb, 11);
    exp_px.delete();
    rb = rise_t.size(); hb = hi_len.size();
    p = 24'($urandom);
    send(p[23:16], p[15:8], p[7:0], 1'b1, acc0);
    bus.valid = 1'b0;
    wait_fd(fb, tf);
    check_stream("s5", rb, hb, 1'b1);
    chk("s5_fd_time", tf - acc0, 1 + PX_CYC + LATCH);

    // Valid/data churn while the holding register is full
    exp_px.delete();
    rb = rise_t.size(); hb = hi_len.size(); fb = fd_t.size(); ub = ur_t.size();
    p = 24'($urandom);
    send(p[23:16], p[15:8], p[7:0], 1'b0, acc0);
    p = 24'($urandom);
    send(p[23:16], p[15:8], p[7:0], 1'b0, acc);
    for (int i = 0; i < 100; i++) begin
      bus.valid = 1'($urandom);
      bus.red   = 8'($urandom);
      bus.green = 8'($urandom);
      bus.blue  = 8'($urandom);
      bus.last  = 1'($urandom);
      tick();
    end
    chk("s6_ready_still_low", bus.ready, 1'b0);
    p = 24'($urandom);
    send(p[23:16], p[15:8], p[7:0], 1'b1, acc);
    bus.valid = 1'b0;
    wait_fd(fb, tf);
    check_stream("s6", rb, hb, 1'b1);
    chk("s6_fd_time", tf - acc0, 1 + 3 * PX_CYC + LATCH);
    chk("s6_no_underrun", ur_t.size() - ub, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
